// File: rtl/booth4_code.sv
// Radix-4 Booth partial-product generator: selects {0,+A,+2A,-A,-2A} for one
// 3-bit multiplier group and registers the (WIDTH+1)-bit signed result.
module booth4_code #(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [2:0]       b_i,
  output logic [WIDTH:0]   booth_o,
  output logic             neg_o,
  output logic             valid_o
);

  logic [WIDTH:0] w_ax;
  logic [WIDTH:0] w_mag;
  logic [WIDTH:0] w_pp;
  logic           w_neg;

  logic [WIDTH:0] r_booth;
  logic           r_neg;
  logic           r_valid;

  assign w_ax = {a_i[WIDTH-1], a_i};

  // Magnitude select first, then a single conditional negate; 111 maps to
  // zero magnitude with no negate so neg_o stays low for -0.
  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    unique case (b_i)
      3'b000: begin w_mag = '0;                     w_neg = 1'b0; end
      3'b001: begin w_mag = w_ax;                   w_neg = 1'b0; end
      3'b010: begin w_mag = w_ax;                   w_neg = 1'b0; end
      3'b011: begin w_mag = {w_ax[WIDTH-1:0], 1'b0}; w_neg = 1'b0; end
      3'b100: begin w_mag = {w_ax[WIDTH-1:0], 1'b0}; w_neg = 1'b1; end
      3'b101: begin w_mag = w_ax;                   w_neg = 1'b1; end
      3'b110: begin w_mag = w_ax;                   w_neg = 1'b1; end
      3'b111: begin w_mag = '0;                     w_neg = 1'b0; end
      default: begin w_mag = '0;                    w_neg = 1'b0; end
    endcase
  end

  always_comb begin
    w_pp = w_mag;
    if (w_neg) begin
      w_pp = ~w_mag + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_booth <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_booth <= w_pp;
        r_neg   <= w_neg;
      end
    end
  end

  assign booth_o = r_booth;
  assign neg_o   = r_neg;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_booth4_code.sv
// Directed-vector bench for booth4_code at WIDTH=128 with hand-computed results.
module tb_booth4_code;

  localparam int WIDTH = 128;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic [WIDTH-1:0] a_i;
  logic [2:0]       b_i;
  logic [WIDTH:0]   booth_o;
  logic             neg_o;
  logic             valid_o;

  int unsigned n_checks;
  int unsigned n_fails;

  booth4_code #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .booth_o (booth_o),
    .neg_o   (neg_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one valid vector, then sample one cycle later.
  task automatic vec(input string tag, input logic [WIDTH-1:0] a, input logic [2:0] b,
                     input logic [WIDTH:0] exp, input logic exp_neg);
    @(negedge clk_i);
    a_i = a;
    b_i = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    check({tag, " booth"}, booth_o, exp);
    check({tag, " neg"}, {{WIDTH{1'b0}}, neg_o}, {{WIDTH{1'b0}}, exp_neg});
    check({tag, " valid"}, {{WIDTH{1'b0}}, valid_o}, {{WIDTH{1'b0}}, 1'b1});
  endtask

  logic [WIDTH:0] sweep_exp[8];
  logic           sweep_neg[8];
  logic [WIDTH:0] held;
  logic [WIDTH-1:0] a_m1, a_m16, a_0f, a_min;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    a_i     = '0;
    b_i     = 3'b000;

    a_m1  = {WIDTH{1'b1}};
    a_m16 = {{124{1'b1}}, 4'h0};
    a_0f  = {4'h0, {124{1'b1}}};
    a_min = {1'b1, {127{1'b0}}};

    sweep_exp[0] = '0;                          sweep_neg[0] = 1'b0;
    sweep_exp[1] = {129{1'b1}};                 sweep_neg[1] = 1'b0;
    sweep_exp[2] = {129{1'b1}};                 sweep_neg[2] = 1'b0;
    sweep_exp[3] = {{128{1'b1}}, 1'b0};         sweep_neg[3] = 1'b0;
    sweep_exp[4] = 129'd2;                      sweep_neg[4] = 1'b1;
    sweep_exp[5] = 129'd1;                      sweep_neg[5] = 1'b1;
    sweep_exp[6] = 129'd1;                      sweep_neg[6] = 1'b1;
    sweep_exp[7] = '0;                          sweep_neg[7] = 1'b0;

    #12;
    check("reset booth", booth_o, '0);
    check("reset neg", {{WIDTH{1'b0}}, neg_o}, '0);
    check("reset valid", {{WIDTH{1'b0}}, valid_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    vec("A2 b110", 128'd2, 3'b110, {1'b1, {127{1'b1}}, 1'b0}, 1'b1);
    vec("A2 b001", 128'd2, 3'b001, 129'd2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      vec($sformatf("Am1 b%0d", i), a_m1, 3'(i), sweep_exp[i], sweep_neg[i]);
    end

    vec("Am16 b011", a_m16, 3'b011, {{124{1'b1}}, 5'b0}, 1'b0);
    vec("Am16 b100", a_m16, 3'b100, 129'd32, 1'b1);
    vec("Am16 b101", a_m16, 3'b101, 129'd16, 1'b1);
    vec("Am16 b000", a_m16, 3'b000, '0, 1'b0);
    vec("Am16 b111", a_m16, 3'b111, '0, 1'b0);

    vec("A0f b011", a_0f, 3'b011, {4'h0, {124{1'b1}}, 1'b0}, 1'b0);
    vec("A0f b100", a_0f, 3'b100, {4'hF, {123{1'b0}}, 2'b10}, 1'b1);
    vec("A0f b101", a_0f, 3'b101, {5'h1F, {123{1'b0}}, 1'b1}, 1'b1);

    vec("Amin b100", a_min, 3'b100, {1'b1, {128{1'b0}}}, 1'b1);
    vec("Amin b011", a_min, 3'b011, {1'b1, {128{1'b0}}}, 1'b0);

    // valid_i low: outputs hold, valid_o drops
    held = {1'b1, {128{1'b0}}};
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i = {4{32'hDEADBEEF}};
    b_i = 3'b101;
    @(posedge clk_i);
    #1;
    check("hold booth", booth_o, held);
    check("hold neg", {{WIDTH{1'b0}}, neg_o}, '0);
    check("hold valid", {{WIDTH{1'b0}}, valid_o}, '0);

    vec("pre-rst", 128'd2, 3'b110, {1'b1, {127{1'b1}}, 1'b0}, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("async rst booth", booth_o, '0);
    check("async rst neg", {{WIDTH{1'b0}}, neg_o}, '0);
    check("async rst valid", {{WIDTH{1'b0}}, valid_o}, '0);
    @(posedge clk_i);
    #1;
    check("rst held booth", booth_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post-rst idle valid", {{WIDTH{1'b0}}, valid_o}, '0);
    vec("post-rst first", 128'd2, 3'b001, 129'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
